// File: rtl/tx_symbols_pkg.sv
// tx_symbols_pkg: K-symbol codes and inserter state shared by the SKP insertion path
package tx_symbols_pkg;
  localparam logic [7:0] COM_SYM = 8'hBC;
  localparam logic [7:0] SKP_SYM = 8'h1C;
  typedef enum logic {PASS, SEND_SKP} state_t;
endpackage

// File: rtl/skp_interval_timer.sv
// skp_interval_timer: free-running interval counter feeding a saturating count of owed ordered sets
module skp_interval_timer #(
  parameter int SKP_INTERVAL = 1180,
  parameter int MAX_PENDING = 3
) (
  input  logic tx_clk,
  input  logic rst,
  input  logic enable,
  input  logic consume,
  output logic pending_nz
);
  localparam int TW = $clog2(SKP_INTERVAL);
  localparam int PW = $clog2(MAX_PENDING + 1);
  logic [TW-1:0] timer;
  logic [PW-1:0] pending;
  logic req;
  assign req = enable && timer == TW'(SKP_INTERVAL - 1);
  assign pending_nz = pending != '0;
  always_ff @(posedge tx_clk) begin
    if (rst || !enable) begin
      timer <= '0;
      pending <= '0;
    end else begin
      timer <= req ? '0 : timer + 1'b1;
      pending <= consume && !req ? pending - 1'b1 :
                 req && !consume && pending != PW'(MAX_PENDING) ? pending + 1'b1 : pending;
    end
  end
endmodule

// File: rtl/tx_skp_inserter.sv
// tx_skp_inserter: injects COM + SKP_COUNT x SKP ordered sets into the pre-8b/10b stream between packets
module tx_skp_inserter
  import tx_symbols_pkg::*;
#(
  parameter int SKP_INTERVAL = 1180,
  parameter int SKP_COUNT = 3,
  parameter int MAX_PENDING = 3
) (
  input  logic       tx_clk,
  input  logic       rst,
  input  logic       skp_enable,
  input  logic       tx_in_packet,
  input  logic [7:0] data_in,
  input  logic       data_k_in,
  input  logic       data_valid_in,
  output logic       data_ready,
  output logic [7:0] data_out,
  output logic       data_k_out,
  output logic       data_valid_out,
  output logic       skp_inserted
);
  localparam int CW = $clog2(SKP_COUNT + 1);
  state_t state;
  logic [CW-1:0] skp_cnt;
  logic pending_nz;
  logic start;
  assign start = state == PASS && pending_nz && skp_enable && !tx_in_packet;
  assign data_ready = !rst && state == PASS && !start;
  skp_interval_timer #(
    .SKP_INTERVAL(SKP_INTERVAL),
    .MAX_PENDING(MAX_PENDING)
  ) u_timer (
    .tx_clk(tx_clk),
    .rst(rst),
    .enable(skp_enable),
    .consume(start),
    .pending_nz(pending_nz)
  );
  always_ff @(posedge tx_clk) begin
    if (rst) begin
      state <= PASS;
      skp_cnt <= '0;
      data_out <= '0;
      data_k_out <= 1'b0;
      data_valid_out <= 1'b0;
      skp_inserted <= 1'b0;
    end else if (state == SEND_SKP) begin
      data_out <= SKP_SYM;
      data_k_out <= 1'b1;
      data_valid_out <= 1'b1;
      skp_inserted <= 1'b0;
      skp_cnt <= skp_cnt + 1'b1;
      if (skp_cnt == CW'(SKP_COUNT - 1)) state <= PASS;
    end else if (start) begin
      data_out <= COM_SYM;
      data_k_out <= 1'b1;
      data_valid_out <= 1'b1;
      skp_inserted <= 1'b1;
      skp_cnt <= '0;
      state <= SEND_SKP;
    end else begin
      skp_inserted <= 1'b0;
      data_valid_out <= data_valid_in;
      if (data_valid_in) begin
        data_out <= data_in;
        data_k_out <= data_k_in;
      end
    end
  end
endmodule

// File: tb/tb_tx_skp_inserter.sv
// tb_tx_skp_inserter: randomized and directed stimulus checked against a symbol-queue reference model
module tb_tx_skp_inserter;
  localparam int INTV = 16;
  localparam int CNT = 3;
  localparam int MAXP = 3;
  logic tx_clk = 1'b0;
  logic rst = 1'b1;
  logic skp_enable = 1'b0;
  logic tx_in_packet = 1'b0;
  logic [7:0] data_in = '0;
  logic data_k_in = 1'b0;
  logic data_valid_in = 1'b0;
  logic data_ready;
  logic [7:0] data_out;
  logic data_k_out;
  logic data_valid_out;
  logic skp_inserted;
  int n_cmp = 0;
  int n_bad = 0;
  int m_count = 0;
  int m_pending = 0;
  logic [8:0] m_q[$];
  logic [7:0] e_data = '0;
  logic e_k = 1'b0;
  logic e_valid = 1'b0;
  logic e_ins = 1'b0;
  logic e_ready = 1'b0;
  logic [7:0] next_byte = '0;
  logic armed = 1'b0;
  int dut_sets = 0;
  int mdl_sets = 0;

  tx_skp_inserter #(.SKP_INTERVAL(INTV), .SKP_COUNT(CNT), .MAX_PENDING(MAXP)) dut (
    .tx_clk(tx_clk),
    .rst(rst),
    .skp_enable(skp_enable),
    .tx_in_packet(tx_in_packet),
    .data_in(data_in),
    .data_k_in(data_k_in),
    .data_valid_in(data_valid_in),
    .data_ready(data_ready),
    .data_out(data_out),
    .data_k_out(data_k_out),
    .data_valid_out(data_valid_out),
    .skp_inserted(skp_inserted)
  );

  always #5 tx_clk = ~tx_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic en, input logic pkt, input logic vld, input logic k);
    logic busy, start, req;
    @(negedge tx_clk);
    if (armed) begin
      check("valid", data_valid_out, e_valid);
      check("data", data_out, e_data);
      check("k", data_k_out, e_k);
      check("skp_ins", skp_inserted, e_ins);
      if (data_valid_out === 1'b1 && skp_inserted === 1'b1) dut_sets++;
    end
    rst = r;
    skp_enable = en;
    tx_in_packet = pkt;
    data_valid_in = vld;
    data_in = next_byte;
    data_k_in = k;
    #1;
    if (r) begin
      m_count = 0;
      m_pending = 0;
      m_q.delete();
      e_data = '0;
      e_k = 1'b0;
      e_valid = 1'b0;
      e_ins = 1'b0;
      e_ready = 1'b0;
    end else begin
      busy = m_q.size() > 0;
      start = !busy && m_pending > 0 && en && !pkt;
      e_ready = !busy && !start;
      req = en && (m_count % INTV == INTV - 1);
      m_count = en ? m_count + 1 : 0;
      if (!en) m_pending = 0;
      else if (req && !start) m_pending = m_pending < MAXP ? m_pending + 1 : MAXP;
      else if (start && !req) m_pending--;
      e_ins = start;
      if (start) begin
        m_q.push_back({1'b1, 8'hBC});
        repeat (CNT) m_q.push_back({1'b1, 8'h1C});
        mdl_sets++;
      end
      if (m_q.size() > 0) begin
        {e_k, e_data} = m_q.pop_front();
        e_valid = 1'b1;
      end else if (vld && e_ready) begin
        e_data = next_byte;
        e_k = k;
        e_valid = 1'b1;
      end else e_valid = 1'b0;
    end
    check("ready", data_ready, e_ready);
    if (vld && e_ready) next_byte++;
    armed = 1'b1;
  endtask

  initial begin
    int w;
    logic pkt, en;
    repeat (3) cycle(1, 1, 0, 1, 0);
    repeat (40) cycle(0, 1, 0, 1, 0);
    repeat (40) cycle(0, 1, 1, 1, 0);
    repeat (30) cycle(0, 1, 0, 1, 0);
    repeat (100) cycle(0, 1, 1, 1, 0);
    repeat (40) cycle(0, 1, 0, 1, 0);
    repeat (50) cycle(0, 0, 0, 1, 0);
    w = 0;
    while (m_q.size() != 1 && w < 200) begin
      cycle(0, 1, 0, 1, 0);
      w++;
    end
    check("rst_wait", w < 200, 1'b1);
    repeat (2) cycle(1, 1, 0, 1, 0);
    repeat (40) cycle(0, 1, 0, 1, 0);
    for (int i = 0; i < 60; i++) cycle(0, 1, 0, i[0], 0);
    pkt = 1'b0;
    en = 1'b1;
    repeat (2000) begin
      if ($urandom_range(0, 14) == 0) pkt = !pkt;
      if ($urandom_range(0, 60) == 0) en = !en;
      cycle($urandom_range(0, 199) == 0, en, pkt, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
    end
    repeat (10) cycle(0, 0, 0, 0, 0);
    check("set_count", dut_sets, mdl_sets);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
